// File: rtl/dm_jtag_pkg.sv
// Shared JTAG debug-transport types: DTMCS layout, DMI op/error codes and
// the request/response payloads exchanged with the debug module.
package dm_jtag_pkg;

    localparam logic [3:0]  DtmVersion      = 4'd1;
    localparam int unsigned DmiDataWidth    = 32;
    localparam int unsigned DmiReqAddrWidth = 7;

    typedef enum logic [1:0] {
        DtmNop   = 2'd0,
        DtmRead  = 2'd1,
        DtmWrite = 2'd2,
        DtmRsvd  = 2'd3
    } dtm_op_e;

    typedef enum logic [1:0] {
        DmiOk     = 2'd0,
        DmiFailed = 2'd2,
        DmiBusy   = 2'd3
    } dmi_error_e;

    typedef struct packed {
        logic [13:0] zero1;
        logic        dmihardreset;
        logic        dmireset;
        logic        zero0;
        logic [2:0]  idle;
        logic [1:0]  dmistat;
        logic [5:0]  abits;
        logic [3:0]  version;
    } dtmcs_t;

    typedef struct packed {
        logic [DmiReqAddrWidth-1:0] addr;
        logic [DmiDataWidth-1:0]    data;
        dtm_op_e                    op;
    } dmi_req_t;

    typedef struct packed {
        logic [DmiDataWidth-1:0] data;
        logic [1:0]              resp;
    } dmi_resp_t;

endpackage

// File: rtl/dmi_jtag_dr.sv
// DTMCS/DMI data registers on TCK plus the DMI transaction FSM that turns a
// DMI update into a request/response handshake toward the debug module.
module dmi_jtag_dr
    import dm_jtag_pkg::*;
#(
    parameter int unsigned AddrWidth  = 7,
    parameter logic [2:0]  IdleCycles = 3'd1
) (
    input  logic                 tck_i,
    input  logic                 trst_ni,
    input  logic                 dmi_clear_i,
    input  logic                 capture_i,
    input  logic                 shift_i,
    input  logic                 update_i,
    input  logic                 tdi_i,
    input  logic                 dtmcs_select_i,
    output logic                 dtmcs_tdo_o,
    input  logic                 dmi_select_i,
    output logic                 dmi_tdo_o,
    output logic                 dmi_rst_no,
    output logic                 dmi_req_valid_o,
    input  logic                 dmi_req_ready_i,
    output logic [AddrWidth-1:0] dmi_req_addr_o,
    output logic [31:0]          dmi_req_data_o,
    output logic [1:0]           dmi_req_op_o,
    input  logic                 dmi_resp_valid_i,
    output logic                 dmi_resp_ready_o,
    input  logic [31:0]          dmi_resp_data_i,
    input  logic [1:0]           dmi_resp_resp_i
);

    localparam int unsigned DmiWidth = AddrWidth + 34;

    localparam logic [2:0] StIdle      = 3'd0;
    localparam logic [2:0] StRead      = 3'd1;
    localparam logic [2:0] StWaitRead  = 3'd2;
    localparam logic [2:0] StWrite     = 3'd3;
    localparam logic [2:0] StWaitWrite = 3'd4;

    logic [2:0]           state_q, state_d;
    dmi_error_e           error_q, error_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [31:0]          data_q, data_d;
    dtmcs_t               dtmcs_q, dtmcs_d;
    logic [DmiWidth-1:0]  dmi_q, dmi_d;
    logic                 req_valid_q, req_valid_d;
    logic                 resp_ready_q, resp_ready_d;
    dtm_op_e              req_op_q, req_op_d;
    logic                 rst_n_q, rst_n_d;

    dtmcs_t    dtmcs_cap;
    dmi_resp_t resp;
    dtm_op_e   dmi_op;
    logic      busy_evt;
    logic      fail_evt;

    // Next-state, shift registers, error tracking and registered outputs
    always_comb begin
        state_d   = state_q;
        error_d   = error_q;
        addr_d    = addr_q;
        data_d    = data_q;
        dtmcs_d   = dtmcs_q;
        dmi_d     = dmi_q;
        rst_n_d   = 1'b1;
        busy_evt  = 1'b0;
        fail_evt  = 1'b0;
        resp.data = dmi_resp_data_i;
        resp.resp = dmi_resp_resp_i;
        dmi_op    = dtm_op_e'(dmi_q[1:0]);

        dtmcs_cap         = '0;
        dtmcs_cap.idle    = IdleCycles;
        dtmcs_cap.dmistat = error_q;
        dtmcs_cap.abits   = 6'(AddrWidth);
        dtmcs_cap.version = DtmVersion;

        unique case (state_q)
            StRead:      if (dmi_req_ready_i) state_d = StWaitRead;
            StWrite:     if (dmi_req_ready_i) state_d = StWaitWrite;
            StWaitRead: begin
                if (dmi_resp_valid_i) begin
                    state_d  = StIdle;
                    data_d   = resp.data;
                    fail_evt = (resp.resp != 2'b00);
                end
            end
            StWaitWrite: begin
                if (dmi_resp_valid_i) begin
                    state_d  = StIdle;
                    fail_evt = (resp.resp != 2'b00);
                end
            end
            default: ;
        endcase

        if (dtmcs_select_i) begin
            if (capture_i) begin
                dtmcs_d = dtmcs_cap;
            end else if (shift_i) begin
                dtmcs_d = dtmcs_t'({tdi_i, dtmcs_q[31:1]});
            end
        end

        // Decisions use the registered state so a response in this cycle still reads busy
        if (dmi_select_i) begin
            if (capture_i) begin
                if (error_q != DmiOk) begin
                    dmi_d = {addr_q, data_q, error_q};
                end else if (state_q != StIdle) begin
                    dmi_d    = {addr_q, data_q, DtmRsvd};
                    busy_evt = 1'b1;
                end else begin
                    dmi_d = {addr_q, data_q, DtmNop};
                end
            end else if (shift_i) begin
                dmi_d = {tdi_i, dmi_q[DmiWidth-1:1]};
            end else if (update_i && (error_q == DmiOk)) begin
                if (state_q != StIdle) begin
                    busy_evt = 1'b1;
                end else if ((dmi_op == DtmRead) || (dmi_op == DtmWrite)) begin
                    addr_d  = dmi_q[DmiWidth-1:34];
                    data_d  = dmi_q[33:2];
                    state_d = (dmi_op == DtmRead) ? StRead : StWrite;
                end
            end
        end

        if (error_q == DmiOk) begin
            if (busy_evt) begin
                error_d = DmiBusy;
            end else if (fail_evt) begin
                error_d = DmiFailed;
            end
        end

        // dmihardreset outranks everything the FSM or a DMI update decided above
        if (dtmcs_select_i && update_i) begin
            if (dtmcs_q.dmihardreset) begin
                error_d = DmiOk;
                state_d = StIdle;
                rst_n_d = 1'b0;
            end else if (dtmcs_q.dmireset) begin
                error_d = DmiOk;
            end
        end

        req_valid_d  = (state_d == StRead) || (state_d == StWrite);
        resp_ready_d = (state_d == StWaitRead) || (state_d == StWaitWrite);
        req_op_d     = (state_d == StRead)  ? DtmRead  :
                       (state_d == StWrite) ? DtmWrite : DtmNop;
    end

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_q      <= StIdle;
            error_q      <= DmiOk;
            addr_q       <= '0;
            data_q       <= '0;
            dtmcs_q      <= '0;
            dmi_q        <= '0;
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b0;
            req_op_q     <= DtmNop;
            rst_n_q      <= 1'b1;
        end else if (dmi_clear_i) begin
            state_q      <= StIdle;
            error_q      <= DmiOk;
            addr_q       <= '0;
            data_q       <= '0;
            dtmcs_q      <= '0;
            dmi_q        <= '0;
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b0;
            req_op_q     <= DtmNop;
            rst_n_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            error_q      <= error_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            dtmcs_q      <= dtmcs_d;
            dmi_q        <= dmi_d;
            req_valid_q  <= req_valid_d;
            resp_ready_q <= resp_ready_d;
            req_op_q     <= req_op_d;
            rst_n_q      <= rst_n_d;
        end
    end

    assign dtmcs_tdo_o      = dtmcs_q[0];
    assign dmi_tdo_o        = dmi_q[0];
    assign dmi_rst_no       = rst_n_q;
    assign dmi_req_valid_o  = req_valid_q;
    assign dmi_req_addr_o   = addr_q;
    assign dmi_req_data_o   = data_q;
    assign dmi_req_op_o     = req_op_q;
    assign dmi_resp_ready_o = resp_ready_q;

endmodule

// File: tb/tb_dmi_jtag_dr.sv
// Directed + randomized bench for dmi_jtag_dr with a memory-backed debug-module
// responder and a transaction-level expectation model.
module tb_dmi_jtag_dr;

    logic        tck_i = 1'b0;
    logic        trst_ni;
    logic        dmi_clear_i;
    logic        capture_i;
    logic        shift_i;
    logic        update_i;
    logic        tdi_i;
    logic        dtmcs_select_i;
    logic        dtmcs_tdo_o;
    logic        dmi_select_i;
    logic        dmi_tdo_o;
    logic        dmi_rst_no;
    logic        dmi_req_valid_o;
    logic        dmi_req_ready_i = 1'b0;
    logic [6:0]  dmi_req_addr_o;
    logic [31:0] dmi_req_data_o;
    logic [1:0]  dmi_req_op_o;
    logic        dmi_resp_valid_i = 1'b0;
    logic        dmi_resp_ready_o;
    logic [31:0] dmi_resp_data_i = 32'h0;
    logic [1:0]  dmi_resp_resp_i = 2'b00;

    dmi_jtag_dr #(.AddrWidth(7), .IdleCycles(3'd1)) dut (
        .tck_i            (tck_i),
        .trst_ni          (trst_ni),
        .dmi_clear_i      (dmi_clear_i),
        .capture_i        (capture_i),
        .shift_i          (shift_i),
        .update_i         (update_i),
        .tdi_i            (tdi_i),
        .dtmcs_select_i   (dtmcs_select_i),
        .dtmcs_tdo_o      (dtmcs_tdo_o),
        .dmi_select_i     (dmi_select_i),
        .dmi_tdo_o        (dmi_tdo_o),
        .dmi_rst_no       (dmi_rst_no),
        .dmi_req_valid_o  (dmi_req_valid_o),
        .dmi_req_ready_i  (dmi_req_ready_i),
        .dmi_req_addr_o   (dmi_req_addr_o),
        .dmi_req_data_o   (dmi_req_data_o),
        .dmi_req_op_o     (dmi_req_op_o),
        .dmi_resp_valid_i (dmi_resp_valid_i),
        .dmi_resp_ready_o (dmi_resp_ready_o),
        .dmi_resp_data_i  (dmi_resp_data_i),
        .dmi_resp_resp_i  (dmi_resp_resp_i)
    );

    always #5 tck_i = ~tck_i;

    int n_checks = 0;
    int n_errors = 0;

    // Environment knobs, written only by the stimulus block
    logic       dm_ready_en = 1'b1;
    logic       resp_hold   = 1'b0;
    logic [1:0] resp_code   = 2'b00;
    int         resp_max_lat = 0;

    // Debug-module responder state, written only by the responder
    bit   [31:0] dm_mem [128];
    logic [40:0] req_log [$];
    bit          pend = 1'b0;
    logic [1:0]  pend_op = 2'b00;
    logic [6:0]  pend_addr = 7'h0;
    logic [31:0] pend_data = 32'h0;
    int          lat = 0;

    // Expectation model
    bit [31:0] m_mem [128];
    int        m_err = 0;
    int        log_idx = 0;

    always @(posedge tck_i or negedge tck_i) begin
        if (tck_i) begin
            if (trst_ni) begin
                if (dmi_resp_valid_i && dmi_resp_ready_o) begin
                    if (pend_op == 2'd2 && dmi_resp_resp_i == 2'd0) dm_mem[pend_addr] = pend_data;
                    pend = 1'b0;
                end
                if (dmi_req_valid_o && dmi_req_ready_i) begin
                    req_log.push_back({dmi_req_addr_o, dmi_req_data_o, dmi_req_op_o});
                    pend      = 1'b1;
                    pend_op   = dmi_req_op_o;
                    pend_addr = dmi_req_addr_o;
                    pend_data = dmi_req_data_o;
                    lat       = int'($urandom_range(0, resp_max_lat));
                end
            end
        end else begin
            dmi_req_ready_i = dm_ready_en;
            if (!trst_ni) begin
                pend             = 1'b0;
                dmi_resp_valid_i = 1'b0;
            end else if (pend && !resp_hold && lat == 0) begin
                dmi_resp_valid_i = 1'b1;
                dmi_resp_data_i  = (pend_op == 2'd1) ? dm_mem[pend_addr] : 32'h0;
                dmi_resp_resp_i  = resp_code;
            end else begin
                dmi_resp_valid_i = 1'b0;
                if (pend && !resp_hold && lat > 0) lat = lat - 1;
            end
        end
    end

    function automatic logic [31:0] dtmcs_exp(input int err);
        return 32'((1 << 12) + (err << 10) + (7 << 4) + 1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge tck_i);
        #1;
    endtask

    task automatic dtmcs_scan(input logic [31:0] din, output logic [31:0] dout);
        dtmcs_select_i = 1'b1;
        capture_i = 1'b1; tick(); capture_i = 1'b0;
        shift_i = 1'b1;
        for (int i = 0; i < 32; i++) begin
            dout[i] = dtmcs_tdo_o;
            tdi_i = din[i];
            tick();
        end
        shift_i = 1'b0;
        update_i = 1'b1; tick(); update_i = 1'b0;
        dtmcs_select_i = 1'b0;
    endtask

    task automatic dmi_scan(input logic [40:0] din, output logic [40:0] dout);
        dmi_select_i = 1'b1;
        capture_i = 1'b1; tick(); capture_i = 1'b0;
        shift_i = 1'b1;
        for (int i = 0; i < 41; i++) begin
            dout[i] = dmi_tdo_o;
            tdi_i = din[i];
            tick();
        end
        shift_i = 1'b0;
        update_i = 1'b1; tick(); update_i = 1'b0;
        dmi_select_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((dmi_req_valid_o || dmi_resp_ready_o || pend) && n < 60) begin
            tick();
            n++;
        end
        chk(tag, 64'(n < 60), 64'(1));
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_valid"},      64'(dmi_req_valid_o),  64'(0));
        chk({pfx, "_resp_ready"}, 64'(dmi_resp_ready_o), 64'(0));
        chk({pfx, "_addr"},       64'(dmi_req_addr_o),   64'(0));
        chk({pfx, "_data"},       64'(dmi_req_data_o),   64'(0));
        chk({pfx, "_op"},         64'(dmi_req_op_o),     64'(0));
        chk({pfx, "_rst_n"},      64'(dmi_rst_no),       64'(1));
        chk({pfx, "_dtmcs_tdo"},  64'(dtmcs_tdo_o),      64'(0));
        chk({pfx, "_dmi_tdo"},    64'(dmi_tdo_o),        64'(0));
    endtask

    task automatic chk_next_req(input string tag, input logic [40:0] exp);
        chk({tag, "_count"}, 64'(req_log.size()), 64'(log_idx + 1));
        if (req_log.size() > log_idx) chk({tag, "_payload"}, 64'(req_log[log_idx]), 64'(exp));
        log_idx = req_log.size();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d32;
        logic [40:0] d41;
        logic [6:0]  a;
        logic [31:0] wd;
        bit          is_wr;

        trst_ni = 1'b1; dmi_clear_i = 1'b0; capture_i = 1'b0; shift_i = 1'b0;
        update_i = 1'b0; tdi_i = 1'b0; dtmcs_select_i = 1'b0; dmi_select_i = 1'b0;
        #2 trst_ni = 1'b0;
        #1 chk_reset_outputs("por");
        tick(); tick();
        #2 trst_ni = 1'b1;
        tick();

        // DTMCS identity after reset
        dtmcs_scan(32'h0, d32);
        chk("dtmcs_reset", 64'(d32), 64'(dtmcs_exp(0)));
        chk("dtmcs_literal", 64'(d32), 64'(32'h0000_1071));

        // Directed write
        dmi_scan({7'h10, 32'hDEAD_BEEF, 2'd2}, d41);
        chk("wr_valid_next", 64'(dmi_req_valid_o), 64'(1));
        chk("wr_addr_o", 64'(dmi_req_addr_o), 64'(7'h10));
        chk("wr_data_o", 64'(dmi_req_data_o), 64'(32'hDEAD_BEEF));
        chk("wr_op_o", 64'(dmi_req_op_o), 64'(2));
        wait_idle("wr_timeout");
        chk_next_req("wr_req", {7'h10, 32'hDEAD_BEEF, 2'd2});
        m_mem[7'h10] = 32'hDEAD_BEEF;
        dmi_scan(41'h0, d41);
        chk("wr_capture", 64'(d41), 64'({7'h10, 32'hDEAD_BEEF, 2'd0}));

        // Directed read of a location seeded by a write
        dmi_scan({7'h11, 32'h1234_5678, 2'd2}, d41);
        wait_idle("seed_timeout");
        chk_next_req("seed_req", {7'h11, 32'h1234_5678, 2'd2});
        m_mem[7'h11] = 32'h1234_5678;
        dmi_scan({7'h11, 32'h0, 2'd1}, d41);
        wait_idle("rd_timeout");
        chk_next_req("rd_req", {7'h11, 32'h0, 2'd1});
        dmi_scan(41'h0, d41);
        chk("rd_capture", 64'(d41), 64'({7'h11, 32'h1234_5678, 2'd0}));

        // Randomized transactions against the memory model
        for (int k = 0; k < 10; k++) begin
            a = 7'($urandom_range(0, 127));
            wd = $urandom;
            is_wr = 1'($urandom_range(0, 1));
            resp_max_lat = int'($urandom_range(0, 3));
            dmi_scan({a, wd, is_wr ? 2'd2 : 2'd1}, d41);
            chk("rnd_valid", 64'(dmi_req_valid_o), 64'(1));
            wait_idle("rnd_timeout");
            chk_next_req("rnd_req", {a, wd, is_wr ? 2'd2 : 2'd1});
            if (is_wr) m_mem[a] = wd;
            dmi_scan(41'h0, d41);
            chk("rnd_capture", 64'(d41), 64'({a, m_mem[a], 2'd0}));
        end
        resp_max_lat = 0;

        // Busy: request stalls, second access reports and latches busy
        dm_ready_en = 1'b0;
        wd = $urandom;
        dmi_scan({7'h20, wd, 2'd2}, d41);
        dmi_scan({7'h21, 32'h5555_AAAA, 2'd2}, d41);
        m_err = 3;
        chk("busy_capture_op", 64'(d41[1:0]), 64'(m_err));
        chk("busy_capture_addr", 64'(d41[40:34]), 64'(7'h20));
        chk("busy_valid_held", 64'(dmi_req_valid_o), 64'(1));
        chk("busy_addr_stable", 64'(dmi_req_addr_o), 64'(7'h20));
        chk("busy_data_stable", 64'(dmi_req_data_o), 64'(wd));
        dtmcs_scan(32'h0, d32);
        chk("busy_dmistat", 64'(d32), 64'(dtmcs_exp(m_err)));
        dm_ready_en = 1'b1;
        wait_idle("busy_timeout");
        chk_next_req("busy_req", {7'h20, wd, 2'd2});
        m_mem[7'h20] = wd;
        dmi_scan(41'h0, d41);
        chk("busy_sticky", 64'(d41[1:0]), 64'(m_err));
        dtmcs_scan(32'h0001_0000, d32);
        chk("dmireset_capture", 64'(d32), 64'(dtmcs_exp(m_err)));
        m_err = 0;
        dtmcs_scan(32'h0, d32);
        chk("dmireset_cleared", 64'(d32), 64'(dtmcs_exp(m_err)));

        // Failed response latches dmistat=2 and blocks later updates
        resp_code = 2'd2;
        dmi_scan({7'h05, 32'h0, 2'd1}, d41);
        wait_idle("fail_timeout");
        chk_next_req("fail_req", {7'h05, 32'h0, 2'd1});
        resp_code = 2'd0;
        m_err = 2;
        dtmcs_scan(32'h0, d32);
        chk("fail_dmistat", 64'(d32), 64'(dtmcs_exp(m_err)));
        dmi_scan({7'h06, 32'hCAFE_F00D, 2'd2}, d41);
        chk("fail_capture_op", 64'(d41[1:0]), 64'(m_err));
        repeat (4) tick();
        chk("fail_update_ignored", 64'(req_log.size()), 64'(log_idx));
        chk("fail_no_valid", 64'(dmi_req_valid_o), 64'(0));
        dtmcs_scan(32'h0001_0000, d32);
        m_err = 0;

        // dmihardreset drops a pending request and pulses dmi_rst_no once
        dm_ready_en = 1'b0;
        dmi_scan({7'h30, 32'h0BAD_0BAD, 2'd2}, d41);
        chk("hr_valid_before", 64'(dmi_req_valid_o), 64'(1));
        dtmcs_scan(32'h0002_0000, d32);
        chk("hr_capture", 64'(d32), 64'(dtmcs_exp(m_err)));
        chk("hr_rst_low", 64'(dmi_rst_no), 64'(0));
        chk("hr_valid_drop", 64'(dmi_req_valid_o), 64'(0));
        tick();
        chk("hr_rst_high", 64'(dmi_rst_no), 64'(1));
        dm_ready_en = 1'b1;
        repeat (4) tick();
        chk("hr_dropped", 64'(req_log.size()), 64'(log_idx));
        dmi_scan(41'h0, d41);
        chk("hr_idle_capture", 64'(d41[1:0]), 64'(0));

        // Synchronous clear aborts a stalled request
        dm_ready_en = 1'b0;
        dmi_scan({7'h40, 32'h1111_2222, 2'd2}, d41);
        chk("clr_valid_before", 64'(dmi_req_valid_o), 64'(1));
        dmi_clear_i = 1'b1; tick(); dmi_clear_i = 1'b0;
        chk("clr_valid", 64'(dmi_req_valid_o), 64'(0));
        chk("clr_addr", 64'(dmi_req_addr_o), 64'(0));
        chk("clr_data", 64'(dmi_req_data_o), 64'(0));
        dm_ready_en = 1'b1;
        repeat (3) tick();
        chk("clr_dropped", 64'(req_log.size()), 64'(log_idx));

        // Async reset in WaitRead, no TCK edge between assertion and check
        resp_hold = 1'b1;
        dmi_scan({7'h11, 32'h0, 2'd1}, d41);
        tick();
        log_idx = req_log.size();
        chk("trst_in_wait", 64'(dmi_resp_ready_o), 64'(1));
        #2 trst_ni = 1'b0;
        #1 chk_reset_outputs("trst");
        @(negedge tck_i);
        #1 trst_ni = 1'b1;
        resp_hold = 1'b0;
        repeat (5) tick();
        chk("trst_no_replay", 64'(req_log.size()), 64'(log_idx));
        chk("trst_valid_after", 64'(dmi_req_valid_o), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmi_jtag_dr.md
# dmi_jtag_dr

Data-register stage directly downstream of the DMI JTAG TAP. It owns the DTMCS (32-bit) and DMI (AddrWidth+34-bit) shift registers clocked by TCK. It also runs the DMI transaction FSM that turns a DMI update into a request/response handshake toward the debug module (the CDC into the system clock is a separate block). It consumes the TAP's capture/shift/update/select strobes and returns the selected register's serial TDO bit.

## Interface
- AddrWidth, 7, DMI address width; reported in dtmcs.abits.
- IdleCycles, 3'd1, value reported in dtmcs.idle.
- tck_i  in  1  JTAG TCK; the only clock.
- trst_ni  in  1  asynchronous, active-low reset.
- dmi_clear_i  in  1  TAP Test-Logic-Reset; synchronous clear of all state.
- capture_i / shift_i / update_i  in  1 each  TAP DR strobes, one TCK each.
- tdi_i  in  1  serial data in.
- dtmcs_select_i  in  1  DTMCS selected by IR.
- dtmcs_tdo_o  out  1  DTMCS serial out.
- dmi_select_i  in  1  DMI selected by IR.
- dmi_tdo_o  out  1  DMI serial out.
- dmi_rst_no  out  1  one-cycle low pulse on dmihardreset.
- dmi_req_valid_o  out  1; dmi_req_ready_i  in  1.
- dmi_req_addr_o  out  AddrWidth; dmi_req_data_o  out  32; dmi_req_op_o  out  2 (1 read, 2 write).
- dmi_resp_valid_i  in  1; dmi_resp_ready_o  out  1.
- dmi_resp_data_i  in  32; dmi_resp_resp_i  in  2 (0 success, else failed).

## Operation
- Both shift registers shift LSB-first when shift_i and their select are high: reg <= {tdi_i, reg[MSB:1]}. TDO is reg[0], combinational.
- DTMCS capture loads {14'b0, 2'b0, 1'b0, IdleCycles, error_q, AddrWidth[5:0], 4'd1}.
- DTMCS update:
  - bit16 (dmireset) clears error_q.
  - bit17 (dmihardreset) clears error_q, forces the FSM to Idle (pending request dropped) and pulses dmi_rst_no low for one cycle.
- DMI shift register layout is {addr, data[31:0], op[1:0]}.
- DMI capture:
  - error_q != 0: load {addr_q, data_q, error_q}.
  - Else FSM not Idle: set error_q = 3 (busy) and load op = 3.
  - Else: load {addr_q, data_q, 2'b00}.
- DMI update:
  - error_q != 0: ignored.
  - FSM not Idle: error_q = 3, request ignored.
  - op = 1: latch addr_q/data_q, go to Read.
  - op = 2: latch addr_q/data_q, go to Write.
  - op = 0 or 3: no action.
- FSM states: Idle, Read, WaitRead, Write, WaitWrite.
  - Read/Write: dmi_req_valid_o = 1, op = 1/2; on dmi_req_ready_i go to WaitRead/WaitWrite.
  - WaitRead/WaitWrite: dmi_resp_ready_o = 1. On dmi_resp_valid_i go to Idle; WaitRead also latches data_q <= dmi_resp_data_i.
  - Any nonzero dmi_resp_resp_i sets error_q = 2 (failed).
- error_q is sticky and takes values 0, 2 or 3. Once nonzero, later errors do not overwrite it.
- Priority: trst_ni > dmi_clear_i > dmihardreset > FSM/update.

## Timing
- Reset/clear values:
  - Outputs: dmi_req_valid_o=0, dmi_resp_ready_o=0, addr/data/op outputs=0, dmi_rst_no=1.
  - Both TDO outputs 0.
  - Internal: FSM Idle, error_q=0, addr_q=0, data_q=0.
- Update in TCK N gives dmi_req_valid_o at N+1.
- addr/data/op stay stable while valid is high and not yet accepted. Valid never drops without ready.
- Minimum read latency, with ready and resp_valid both immediate:
  - update at N, req accepted at N+1, response at N+2, data_q valid at N+3.
  - A capture at N+3 returns op=0 with the read data.
- Same-cycle events are decided on the registered FSM state. Capture or update coincident with the final resp_valid still sees non-Idle and gives busy.
- Reset mid-transaction aborts it immediately; the request is not replayed.

## Structure
- Shared package dm_jtag_pkg holds:
  - dtmcs_t packed struct;
  - dtm_op_e (Nop, Read, Write, Rsvd);
  - dmi_error_e (Ok=0, Failed=2, Busy=3);
  - dmi_req_t / dmi_resp_t structs;
  - DTM version constant (1).
- Single module with no sub-module; the FSM and both shift registers are local.

## Test plan
- Capture/shift 32 bits of DTMCS after reset -> 0x00001071 with the defaults (idle=1, abits=7, version=1).
- DMI write addr 0x10, data 0xDEADBEEF, op 2 -> one request with addr 0x10, data 0xDEADBEEF, op 2. A following capture returns op 0.
- DMI read addr 0x11, response data 0x12345678 resp 0 -> next DMI scan returns {0x11, 0x12345678, 0}.
- Hold dmi_req_ready_i low and issue a second update -> op 3 returned and latched; further updates ignored. DTMCS write bit16 then clears dmistat to 0.
- Response with resp=2 -> dmistat reads 2 and later updates are ignored. Writing dmihardreset mid-transaction -> FSM to Idle, valid drops, dmi_rst_no low for exactly one cycle.
- Assert trst_ni low while in WaitRead -> every output at its reset value immediately, with no TCK edge required.
